// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: req/ack word fetches from on-chip RAM with
// programmable wait states, plus a side load port for the program image.
module instr_mem_responder #(
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 2,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [31:0]      addr_i,
  output logic             ack_o,
  output logic [31:0]      instr_o,
  output logic             err_o,
  output logic             busy_o,
  input  logic             ld_we_i,
  input  logic [IDX_W-1:0] ld_addr_i,
  input  logic [31:0]      ld_data_i,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a request is taken only when req_i is high at an edge in IDLE;
  // ack_o is a single-cycle pulse and instr_o/err_o are meaningful only then.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYC);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [31:0]      r_addr;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic [31:0]      r_mem [DEPTH];

  logic             w_accept;
  logic             w_enter_resp;
  logic [31:0]      w_rd_addr;
  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_err;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:IDX_W+2] != '0);
  endfunction

  // With no wait states the RAM is read on the accepting edge, so the live
  // address must feed the read path while still in IDLE.
  assign w_rd_addr    = (r_state == ST_IDLE) ? addr_i : r_addr;
  assign w_rd_idx     = w_rd_addr[IDX_W+1:2];
  assign w_rd_err     = addr_bad(w_rd_addr);
  assign w_accept     = (r_state == ST_IDLE) && req_i;
  assign w_enter_resp = (w_state_nxt == ST_RESP) && (r_state != ST_RESP);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req_i) begin
          if (LP_WAIT == 4'd0) begin
            w_state_nxt = ST_RESP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = LP_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = 4'd0;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr <= addr_i;
      end
      if (w_enter_resp) begin
        r_err   <= w_rd_err;
        r_rdata <= w_rd_err ? 32'h0 : r_mem[w_rd_idx];
      end
    end
  end

  // Separate write process: a same-edge read above sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (rst_i && ld_we_i) begin
      r_mem[ld_addr_i] <= ld_data_i;
    end
  end

  assign ack_o       = (r_state == ST_RESP);
  assign busy_o      = (r_state != ST_IDLE);
  assign instr_o     = ack_o ? r_rdata : 32'h0;
  assign err_o       = ack_o ? r_err : 1'b0;
  assign dbg_state_o = r_state;

  a_ack_single : assert property (@(posedge clk_i) disable iff (!rst_i)
    ack_o |=> !ack_o);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: one instance with two wait
// states and one with none, sharing clock, reset and load port.
module tb_instr_mem_responder;

  localparam int DEPTH = 256;
  localparam int IDX_W = 8;
  localparam int WC    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             req, req0;
  logic [31:0]      addr, addr0;
  logic             ack, ack0;
  logic [31:0]      instr, instr0;
  logic             err, err0;
  logic             busy, busy0;
  logic [1:0]       dbg, dbg0;
  logic             ld_we;
  logic [IDX_W-1:0] ld_addr;
  logic [31:0]      ld_data;

  instr_mem_responder #(.DEPTH(DEPTH), .WAIT_CYC(WC), .IDX_W(IDX_W)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr),
    .ack_o(ack), .instr_o(instr), .err_o(err), .busy_o(busy),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .dbg_state_o(dbg)
  );

  instr_mem_responder #(.DEPTH(DEPTH), .WAIT_CYC(0), .IDX_W(IDX_W)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .addr_i(addr0),
    .ack_o(ack0), .instr_o(instr0), .err_o(err0), .busy_o(busy0),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .dbg_state_o(dbg0)
  );

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];
  logic [32:0] exp0_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_ack", 33'(ack), 33'(0));
      else check("ack_data", {err, instr}, exp_q.pop_front());
    end
    if (ack0 === 1'b1) begin
      if (exp0_q.size() == 0) check("unexpected_ack0", 33'(ack0), 33'(0));
      else check("ack0_data", {err0, instr0}, exp0_q.pop_front());
    end
  end

  function automatic logic [31:0] word_val(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {16'hC0DE, b, ~b};
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic        exp_err;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic load(input int idx, input logic [31:0] d);
    @(negedge clk);
    ld_we   = 1'b1;
    ld_addr = IDX_W'(idx);
    ld_data = d;
  endtask

  // Request sampled at edge N; ack expected in the cycle after edge N+WC.
  task automatic fetch(input logic [31:0] a, input logic [32:0] e, input string name);
    int lat;
    @(negedge clk);
    req  = 1'b1;
    addr = a;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req  = 1'b0;
    addr = $urandom;
    lat  = 0;
    while (ack !== 1'b1 && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 33'(lat), 33'(WC));
    @(negedge clk);
    check({name, "_ack_pulse"}, {31'h0, ack, busy}, 33'(0));
  endtask

  task automatic fetch0(input logic [31:0] a, input logic [32:0] e, input string name);
    @(negedge clk);
    check({name, "_idle"}, 33'(busy0), 33'(0));
    req0  = 1'b1;
    addr0 = a;
    exp0_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req0  = 1'b0;
    addr0 = $urandom;
    check({name, "_ack_busy"}, {31'h0, ack0, busy0}, 33'b11);
    @(negedge clk);
    check({name, "_done"}, {31'h0, ack0, busy0}, 33'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acks_seen;
    vecs[0] = '{32'h0000_000C, 1'b0, 32'h2022_0001};
    vecs[1] = '{32'h0000_0006, 1'b1, 32'h0};
    vecs[2] = '{32'h0000_0400, 1'b1, 32'h0};
    vecs[3] = '{32'h0000_03FC, 1'b0, word_val(255)};
    vecs[4] = '{32'h0000_0000, 1'b0, word_val(0)};
    vecs[5] = '{32'h0000_0001, 1'b1, 32'h0};
    vecs[6] = '{32'h8000_0010, 1'b1, 32'h0};
    vecs[7] = '{32'h0000_03FF, 1'b1, 32'h0};
    vecs[8] = '{32'h0000_0040, 1'b0, word_val(16)};

    rst = 1'b0; req = 1'b0; req0 = 1'b0; addr = '0; addr0 = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (2) @(negedge clk);
    check("rst_ack_instr", {ack, instr}, 33'(0));
    check("rst_err_busy_dbg", {29'h0, err, busy, dbg}, 33'(0));
    check("rst0_outputs", {ack0 | err0 | busy0, instr0}, 33'(0));
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < DEPTH; k++) load(k, (k == 3) ? 32'h2022_0001 : word_val(k));
    @(negedge clk);
    ld_we = 1'b0;

    for (int i = 0; i < 9; i++)
      fetch(vecs[i].addr, {vecs[i].exp_err, vecs[i].exp_instr}, $sformatf("vec%0d", i));

    // Reset two edges mid-WAIT; load port writes during reset must be dropped.
    @(negedge clk);
    req = 1'b1; addr = 32'h0000_000C;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("wait_busy", 33'(busy), 33'(1));
    rst = 1'b0; ld_we = 1'b1; ld_addr = 8'd7; ld_data = 32'hBAD0_0007;
    @(negedge clk);
    check("midrst_outputs1", {busy | err | ack, instr}, 33'(0));
    @(negedge clk);
    check("midrst_outputs2", {busy | err | ack, instr}, 33'(0));
    rst = 1'b1; ld_we = 1'b0;
    acks_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack === 1'b1) acks_seen++;
    end
    check("aborted_no_ack", 33'(acks_seen), 33'(0));
    fetch(32'h0000_001C, {1'b0, word_val(7)}, "ld_in_reset");

    // req held high: accepts every WC+2 cycles, later addr changes ignored.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_idle", k), {31'h0, ack, busy}, 33'(0));
      req  = 1'b1;
      addr = 32'h20 + 32'(4 * k);
      exp_q.push_back({1'b0, word_val(8 + k)});
      @(posedge clk);
      for (int j = 0; j <= WC; j++) begin
        @(negedge clk);
        addr = 32'h80 + 32'(4 * j);
        check($sformatf("b2b%0d_ack_c%0d", k, j), 33'(ack), 33'(j == WC));
      end
    end
    @(negedge clk);
    req = 1'b0;

    // Load-port write on the RESP-entry edge: old word returned, new word next.
    @(negedge clk);
    req = 1'b1; addr = 32'h0000_0014;
    exp_q.push_back({1'b0, word_val(5)});
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    ld_we = 1'b1; ld_addr = 8'd5; ld_data = 32'hFEED_0005;
    @(negedge clk);
    ld_we = 1'b0;
    check("ld_same_edge_ack", 33'(ack), 33'(1));
    @(negedge clk);
    fetch(32'h0000_0014, {1'b0, 32'hFEED_0005}, "ld_new");

    // Zero-wait-state instance.
    fetch0(32'h0000_000C, {1'b0, 32'h2022_0001}, "z0_word3");
    fetch0(32'h0000_0006, {1'b1, 32'h0}, "z0_misalign");
    fetch0(32'h0000_03FC, {1'b0, word_val(255)}, "z0_last");
    fetch0(32'h0000_0014, {1'b0, 32'hFEED_0005}, "z0_word5");

    repeat (3) @(negedge clk);
    check("exp_q_drained", 33'(exp_q.size()), 33'(0));
    check("exp0_q_drained", 33'(exp0_q.size()), 33'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
